// File: rtl/xc_mp_pkg.sv
// Shared encodings and decode helpers for the sequential multi-precision add/subtract unit.
package xc_mp_pkg;

  typedef enum logic [1:0] {
    XC_MP_MADD3 = 2'd0,
    XC_MP_MSUB3 = 2'd1,
    XC_MP_MADD2 = 2'd2,
    XC_MP_MSUB2 = 2'd3
  } xc_mp_op_e;

  typedef enum logic [1:0] {
    XC_MP_IDLE = 2'd0,
    XC_MP_BUSY = 2'd1,
    XC_MP_DONE = 2'd2
  } xc_mp_state_e;

  function automatic logic is_sub(input xc_mp_op_e op);
    return (op == XC_MP_MSUB3) || (op == XC_MP_MSUB2);
  endfunction

  function automatic logic has_cin(input xc_mp_op_e op);
    return (op == XC_MP_MADD3) || (op == XC_MP_MSUB3);
  endfunction

  // Subtraction runs as a + ~b + cin, so the external borrow-in is inverted
  // and the 2-operand subtract starts with a carry of 1.
  function automatic logic initial_carry(input xc_mp_op_e op, input logic c0);
    if (has_cin(op)) return c0 ^ is_sub(op);
    return is_sub(op);
  endfunction

endpackage

// File: rtl/xc_mp_slice_adder.sv
// One SLICE-bit ripple step: sum/cout of a + (b or ~b) + cin.
module xc_mp_slice_adder #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             inv_b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE-1:0] b_eff;
  logic [SLICE:0]   total;

  always_comb begin
    b_eff = inv_b ? ~b : b;
    total = {1'b0, a} + {1'b0, b_eff} + {{SLICE{1'b0}}, cin};
  end

  assign sum  = total[SLICE-1:0];
  assign cout = total[SLICE];

endmodule

// File: rtl/xc_mp_addsub_seq.sv
// Multi-cycle multi-precision add/subtract: SLICE bits per cycle with a registered
// ripple carry, producing a {hi,lo} writeback for an even destination register pair.
module xc_mp_addsub_seq
  import xc_mp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SLICE = 8
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_rs3,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [4:0]      rsp_rd,
  output logic            rsp_wen,
  output logic [XLEN-1:0] rsp_lo,
  output logic [XLEN-1:0] rsp_hi,
  output logic            busy
);

  localparam int NSLICE = XLEN / SLICE;
  localparam int CNT_W  = $clog2(NSLICE) + 1;

  generate
    if ((XLEN % SLICE) != 0) begin : g_bad_slice
      $error("xc_mp_addsub_seq: XLEN must be a multiple of SLICE");
    end
  endgenerate

  xc_mp_state_e     state_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  res_q;
  logic             sub_q;
  logic             carry_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] cnt_q;

  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic [XLEN-1:0]  res_next;
  logic             last_slice;
  logic             unused_rs3;

  assign unused_rs3 = ^req_rs3[XLEN-1:1];

  // Operands shift right each cycle so the active slice is always the low SLICE bits.
  xc_mp_slice_adder #(.SLICE(SLICE)) u_slice_adder (
    .a     (a_q[SLICE-1:0]),
    .b     (b_q[SLICE-1:0]),
    .inv_b (sub_q),
    .cin   (carry_q),
    .sum   (slice_sum),
    .cout  (slice_cout)
  );

  // New slice enters at the top; after NSLICE steps the first slice sits at bit 0.
  assign res_next   = XLEN'({slice_sum, res_q} >> SLICE);
  assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q   <= XC_MP_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      rsp_lo    <= '0;
      rsp_hi    <= '0;
      rsp_rd    <= '0;
      rsp_wen   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        XC_MP_IDLE: begin
          if (req_valid && !flush) begin
            a_q       <= req_rs1;
            b_q       <= req_rs2;
            sub_q     <= is_sub(xc_mp_op_e'(req_op));
            carry_q   <= initial_carry(xc_mp_op_e'(req_op), req_rs3[0]);
            rd_q      <= req_rd & 5'b11110;
            cnt_q     <= '0;
            state_q   <= XC_MP_BUSY;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        // ---- slice processing stage ----
        XC_MP_BUSY: begin
          if (flush) begin
            state_q   <= XC_MP_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            a_q     <= a_q >> SLICE;
            b_q     <= b_q >> SLICE;
            res_q   <= res_next;
            carry_q <= slice_cout;
            if (last_slice) begin
              state_q   <= XC_MP_DONE;
              rsp_valid <= 1'b1;
              rsp_rd    <= rd_q;
              rsp_wen   <= (rd_q != 5'd0);
              rsp_lo    <= (rd_q != 5'd0) ? res_next : '0;
              rsp_hi    <= {{(XLEN-1){1'b0}}, slice_cout ^ sub_q};
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        // ---- response hold stage ----
        XC_MP_DONE: begin
          if (flush || rsp_ready) begin
            state_q   <= XC_MP_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_q   <= XC_MP_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
